matrix_rf_row_sequencer: RTL and testbench

//  Shares one read port of the matrix register file between N_REQ requesters (e.g. matmul operand feeders).

---
 rtl/matrix_rf_row_sequencer.sv | 133 +++++++++++++
 tb/tb_matrix_rf_row_sequencer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_rf_row_sequencer.sv
// Round-robin arbiter plus row streamer for one matrix register-file read port.
// Optional MATRIX_RF_SEQ_FLUSH_EN adds flush_i to abandon the current transfer.
module matrix_rf_row_sequencer #(
  parameter int N_REQ  = 3,
  parameter int N_REGS = 8,
  parameter int RLEN   = 128,
  localparam int N_ROWS = RLEN / 32,
  localparam int RW     = (N_REGS > 1) ? $clog2(N_REGS) : 1,
  localparam int CW     = (N_ROWS > 1) ? $clog2(N_ROWS) : 1,
  localparam int IW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
`ifdef MATRIX_RF_SEQ_FLUSH_EN
  input  logic                flush_i,
`endif
  input  logic [N_REQ-1:0]    req_valid_i,
  input  logic [N_REQ*RW-1:0] req_reg_i,
  output logic [N_REQ-1:0]    req_ready_o,
  output logic [RW-1:0]       rf_raddr_o,
  output logic [CW-1:0]       rf_rrowaddr_o,
  input  logic [RLEN-1:0]     rf_rdata_i,
  output logic                row_valid_o,
  input  logic                row_ready_i,
  output logic [RLEN-1:0]     row_data_o,
  output logic [CW-1:0]       row_idx_o,
  output logic                row_last_o,
  output logic [IW-1:0]       row_id_o,
  output logic                busy_o
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          state_reg;
  logic [IW-1:0]   rr_reg;
  logic [IW-1:0]   id_reg;
  logic [CW-1:0]   cnt_reg;
  logic [RW-1:0]   raddr_reg;
  logic [RW-1:0]   req_reg [N_REQ];
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   rr_next;
  logic            flush;
  logic            capture;
  logic            cnt_last;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req_slice
    assign req_reg[gi] = req_reg_i[gi*RW +: RW];
  end

`ifdef MATRIX_RF_SEQ_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Scan offsets from the highest down so the lowest offset from rr wins.
  always_comb begin
    logic [IW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(rr_reg) + k) % N_REQ);
      if (req_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign rr_next  = IW'((int'(win_idx) + 1) % N_REQ);
  assign capture  = !row_valid_o || row_ready_i;
  assign cnt_last = (cnt_reg == CW'(N_ROWS - 1));

  assign req_ready_o   = (state_reg == IDLE && win_found && !flush) ? (N_REQ'(1) << win_idx) : '0;
  assign rf_raddr_o    = raddr_reg;
  assign rf_rrowaddr_o = cnt_reg;
  assign busy_o        = (state_reg == STREAM) || row_valid_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      rr_reg      <= '0;
      id_reg      <= '0;
      cnt_reg     <= '0;
      raddr_reg   <= '0;
      row_valid_o <= 1'b0;
      row_data_o  <= '0;
      row_idx_o   <= '0;
      row_last_o  <= 1'b0;
      row_id_o    <= '0;
    end else if (flush) begin
      // Abandon the transfer; the arbitration pointer keeps its position.
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      raddr_reg   <= '0;
      row_valid_o <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (row_valid_o && row_ready_i) row_valid_o <= 1'b0;
          if (win_found) begin
            state_reg <= STREAM;
            raddr_reg <= req_reg[win_idx];
            id_reg    <= win_idx;
            cnt_reg   <= '0;
            rr_reg    <= rr_next;
          end
        end
        STREAM: begin
          // Without capture the address is held, so the RF is simply re-read.
          if (capture) begin
            row_valid_o <= 1'b1;
            row_data_o  <= rf_rdata_i;
            row_idx_o   <= cnt_reg;
            row_id_o    <= id_reg;
            row_last_o  <= cnt_last;
            if (cnt_last) begin
              state_reg <= IDLE;
              cnt_reg   <= '0;
              raddr_reg <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_rf_row_sequencer.sv
// Bench for matrix_rf_row_sequencer: vector table, directed corner sequences and
// a randomized run checked against a transaction-level reference model.
module tb_matrix_rf_row_sequencer;
  localparam int N_REQ  = 3;
  localparam int N_REGS = 8;
  localparam int RLEN   = 128;
  localparam int N_ROWS = RLEN / 32;
  localparam int RW     = 3;
  localparam int CW     = 2;
  localparam int IW     = 2;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic [N_REQ-1:0]    req_valid_i = '0;
  logic [N_REQ*RW-1:0] req_reg_i = '0;
  logic [N_REQ-1:0]    req_ready_o;
  logic [RW-1:0]       rf_raddr_o;
  logic [CW-1:0]       rf_rrowaddr_o;
  logic [RLEN-1:0]     rf_rdata_i;
  logic                row_valid_o;
  logic                row_ready_i = 1'b1;
  logic [RLEN-1:0]     row_data_o;
  logic [CW-1:0]       row_idx_o;
  logic                row_last_o;
  logic [IW-1:0]       row_id_o;
  logic                busy_o;
  logic                fl;
`ifdef MATRIX_RF_SEQ_FLUSH_EN
  logic                flush_i = 1'b0;
  assign fl = flush_i;
`else
  assign fl = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  matrix_rf_row_sequencer #(.N_REQ(N_REQ), .N_REGS(N_REGS), .RLEN(RLEN)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
`ifdef MATRIX_RF_SEQ_FLUSH_EN
    .flush_i(flush_i),
`endif
    .req_valid_i(req_valid_i), .req_reg_i(req_reg_i), .req_ready_o(req_ready_o),
    .rf_raddr_o(rf_raddr_o), .rf_rrowaddr_o(rf_rrowaddr_o), .rf_rdata_i(rf_rdata_i),
    .row_valid_o(row_valid_o), .row_ready_i(row_ready_i), .row_data_o(row_data_o),
    .row_idx_o(row_idx_o), .row_last_o(row_last_o), .row_id_o(row_id_o), .busy_o(busy_o)
  );

  // Register-file contents as a pure function of (register, row).
  function automatic logic [RLEN-1:0] rf_word(input int r, input int c);
    logic [RLEN-1:0] v;
    for (int k = 0; k < RLEN / 32; k++) v[k*32 +: 32] = 32'hA500_0000 ^ 32'(r << 16) ^ 32'(c << 8) ^ 32'(k);
    return v;
  endfunction

  always_comb rf_rdata_i = rf_word(int'(rf_raddr_o), int'(rf_rrowaddr_o));

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [RLEN-1:0] act, input logic [RLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_reg(input int i, input int r);
    req_reg_i[i*RW +: RW] = RW'(r);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    req_valid_i = '0;
    row_ready_i = 1'b1;
`ifdef MATRIX_RF_SEQ_FLUSH_EN
    flush_i = 1'b0;
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, req_ready_o, 0);
    chk({tag, "_raddr"}, rf_raddr_o, 0);
    chk({tag, "_rrow"}, rf_rrowaddr_o, 0);
    chk({tag, "_valid"}, row_valid_o, 0);
    chk({tag, "_data"}, row_data_o, 0);
    chk({tag, "_idx"}, row_idx_o, 0);
    chk({tag, "_last"}, row_last_o, 0);
    chk({tag, "_id"}, row_id_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
  endtask

  function automatic int gnt_index(input logic [N_REQ-1:0] g);
    for (int i = 0; i < N_REQ; i++) if (g[i]) return i;
    return -1;
  endfunction

  // Round-robin choice: first valid requester at or after rr, wrapping.
  function automatic int pick(input logic [N_REQ-1:0] v, input int rr);
    for (int k = 0; k < N_REQ; k++) if (v[(rr + k) % N_REQ]) return (rr + k) % N_REQ;
    return -1;
  endfunction

  typedef struct {
    logic [2:0] vld;
    logic [2:0] rg;
    logic       rdy;
    logic [2:0] gnt;
    logic       rv;
    logic [1:0] idx;
    logic       last;
    logic       busy;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic [2:0] vld, input logic [2:0] rg, input logic rdy,
                              input logic [2:0] gnt, input logic rv, input logic [1:0] idx,
                              input logic last, input logic busy);
    vec_t v;
    v = '{vld, rg, rdy, gnt, rv, idx, last, busy};
    vt.push_back(v);
  endfunction

  // Reference model state (transaction level).
  bit m_stream, m_ov, m_olast;
  int m_reg, m_id, m_row, m_rr, m_oidx, m_oid, m_oreg;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int found;
    logic [N_REQ-1:0] got;
    logic [N_REQ-1:0] prev_gnt;

    // Reset state
    repeat (2) @(negedge clk_i);
    #1;
    chk_all_zero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single request, full throughput, then same request with back-pressure
    add(3'b001, 5, 1, 3'b001, 0, 0, 0, 0);
    add(3'b000, 0, 1, 3'b000, 0, 0, 0, 1);
    add(3'b000, 0, 1, 3'b000, 1, 0, 0, 1);
    add(3'b000, 0, 1, 3'b000, 1, 1, 0, 1);
    add(3'b000, 0, 1, 3'b000, 1, 2, 0, 1);
    add(3'b000, 0, 1, 3'b000, 1, 3, 1, 1);
    add(3'b000, 0, 1, 3'b000, 0, 0, 0, 0);
    add(3'b001, 5, 1, 3'b001, 0, 0, 0, 0);
    add(3'b000, 0, 1, 3'b000, 0, 0, 0, 1);
    add(3'b000, 0, 1, 3'b000, 1, 0, 0, 1);
    add(3'b000, 0, 0, 3'b000, 1, 1, 0, 1);
    add(3'b000, 0, 0, 3'b000, 1, 1, 0, 1);
    add(3'b000, 0, 0, 3'b000, 1, 1, 0, 1);
    add(3'b000, 0, 1, 3'b000, 1, 1, 0, 1);
    add(3'b000, 0, 1, 3'b000, 1, 2, 0, 1);
    add(3'b000, 0, 1, 3'b000, 1, 3, 1, 1);
    add(3'b000, 0, 1, 3'b000, 0, 0, 0, 0);
    for (int n = 0; n < vt.size(); n++) begin
      @(negedge clk_i);
      req_valid_i = vt[n].vld;
      set_reg(0, int'(vt[n].rg));
      row_ready_i = vt[n].rdy;
      #1;
      chk("tbl_gnt", req_ready_o, vt[n].gnt);
      chk("tbl_valid", row_valid_o, vt[n].rv);
      chk("tbl_busy", busy_o, vt[n].busy);
      if (vt[n].rv) begin
        chk("tbl_idx", row_idx_o, vt[n].idx);
        chk("tbl_last", row_last_o, vt[n].last);
        chk("tbl_id", row_id_o, 0);
        chk("tbl_data", row_data_o, rf_word(5, int'(vt[n].idx)));
      end
      if (req_ready_o != 0) $display("txn table step=%0d grant=%b", n, req_ready_o);
    end

    // All three requesters continuously valid: grants 0,1,2,0 every N_ROWS+1 cycles
    begin
      int g_cyc[$], g_id[$], e_id[$], e_idx[$];
      int first_row;
      first_row = -1;
      do_reset();
      req_valid_i = 3'b111;
      set_reg(0, 1); set_reg(1, 2); set_reg(2, 3);
      row_ready_i = 1'b1;
      for (int cyc = 0; cyc < 25; cyc++) begin
        #1;
        if (req_ready_o != 0) begin
          g_cyc.push_back(cyc);
          g_id.push_back(gnt_index(req_ready_o));
          for (int r = 0; r < N_ROWS; r++) begin
            e_id.push_back(gnt_index(req_ready_o));
            e_idx.push_back(r);
          end
          $display("txn rr cyc=%0d grant=%b", cyc, req_ready_o);
        end
        if (row_valid_o) begin
          if (first_row < 0) first_row = cyc;
          if (e_id.size() == 0) chk("t3_extra_row", 1, 0);
          else begin
            int eid, eidx;
            eid = e_id.pop_front();
            eidx = e_idx.pop_front();
            chk("t3_row_id", row_id_o, eid);
            chk("t3_row_idx", row_idx_o, eidx);
            chk("t3_row_data", row_data_o, rf_word(eid + 1, eidx));
          end
        end
        @(negedge clk_i);
      end
      chk("t3_ngrants_ge4", g_id.size() >= 4, 1);
      if (g_id.size() >= 4) begin
        chk("t3_first_row_lat", first_row - g_cyc[0], 2);
        chk("t3_g0", g_id[0], 0);
        chk("t3_g1", g_id[1], 1);
        chk("t3_g2", g_id[2], 2);
        chk("t3_g3", g_id[3], 0);
        for (int k = 1; k < 4; k++) chk("t3_gap", g_cyc[k] - g_cyc[k-1], N_ROWS + 1);
      end
    end

    // Round-robin fairness: after req1, req2 goes before req0
    do_reset();
    req_valid_i = 3'b010;
    set_reg(1, 4);
    #1;
    chk("t4_first", req_ready_o, 3'b010);
    @(negedge clk_i);
    req_valid_i = 3'b101;
    set_reg(0, 2); set_reg(2, 6);
    got = '0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req_ready_o != 0) begin got = req_ready_o; break; end
      @(negedge clk_i);
    end
    chk("t4_rr_second", got, 3'b100);
    $display("txn fairness grant=%b", got);
    @(negedge clk_i);
    req_valid_i = 3'b001;
    got = '0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req_ready_o != 0) begin got = req_ready_o; break; end
      @(negedge clk_i);
    end
    chk("t4_rr_third", got, 3'b001);

    // Asynchronous reset during row 2 of reg7, then restart
    do_reset();
    req_valid_i = 3'b100;
    set_reg(2, 7);
    #1;
    chk("t5_gnt", req_ready_o, 3'b100);
    @(negedge clk_i);
    req_valid_i = '0;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (row_valid_o && row_idx_o == 2) begin found = 1; break; end
      @(negedge clk_i);
    end
    chk("t5_row2_seen", found, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_all_zero("t5_async");
    @(negedge clk_i);
    rst_ni = 1'b1;
    req_valid_i = 3'b100;
    #1;
    chk("t5_regnt", req_ready_o, 3'b100);
    @(negedge clk_i);
    req_valid_i = '0;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (row_valid_o) begin found = 1; break; end
      @(negedge clk_i);
    end
    chk("t5_restart_seen", found, 1);
    chk("t5_restart_idx", row_idx_o, 0);
    chk("t5_restart_id", row_id_o, 2);
    chk("t5_restart_data", row_data_o, rf_word(7, 0));
    $display("txn restart reg=7 idx=%0d", row_idx_o);

`ifdef MATRIX_RF_SEQ_FLUSH_EN
    // Flush with row 1 pending, then flush while a request waits in IDLE
    do_reset();
    req_valid_i = 3'b001;
    set_reg(0, 3);
    #1;
    chk("t6_gnt", req_ready_o, 3'b001);
    @(negedge clk_i);
    req_valid_i = '0;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (row_valid_o) begin found = 1; break; end
      @(negedge clk_i);
    end
    chk("t6_row0_seen", found, 1);
    @(negedge clk_i);
    row_ready_i = 1'b0;
    req_valid_i = 3'b010;
    set_reg(1, 2);
    flush_i = 1'b1;
    #1;
    chk("t6_row1_pending", row_idx_o, 1);
    chk("t6_flush_nognt", req_ready_o, 0);
    @(negedge clk_i);
    flush_i = 1'b0;
    #1;
    chk("t6_after_valid", row_valid_o, 0);
    chk("t6_after_busy", busy_o, 0);
    chk("t6_next_rr", req_ready_o, 3'b010);
    do_reset();
    req_valid_i = 3'b001;
    flush_i = 1'b1;
    #1;
    chk("t6_idle_flush_gnt", req_ready_o, 0);
    @(negedge clk_i);
    flush_i = 1'b0;
    #1;
    chk("t6_idle_flush_busy", busy_o, 0);
    chk("t6_idle_flush_rr", req_ready_o, 3'b001);
`endif

    // Randomized run against the reference model
    do_reset();
    m_stream = 0; m_ov = 0; m_olast = 0;
    m_reg = 0; m_id = 0; m_row = 0; m_rr = 0; m_oidx = 0; m_oid = 0; m_oreg = 0;
    prev_gnt = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int w;
      logic [N_REQ-1:0] exp_gnt;
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid_i[i] && !prev_gnt[i]) begin
          if ($urandom_range(0, 9) == 0) req_valid_i[i] = 1'b0;
        end else begin
          req_valid_i[i] = ($urandom_range(0, 2) == 0);
          set_reg(i, int'($urandom_range(0, N_REGS - 1)));
        end
      end
      row_ready_i = ($urandom_range(0, 3) != 0);
`ifdef MATRIX_RF_SEQ_FLUSH_EN
      flush_i = ($urandom_range(0, 39) == 0);
`endif
      #1;
      w = (!m_stream && !fl) ? pick(req_valid_i, m_rr) : -1;
      exp_gnt = (w >= 0) ? N_REQ'(1 << w) : '0;
      chk("rnd_gnt", req_ready_o, exp_gnt);
      chk("rnd_valid", row_valid_o, m_ov);
      chk("rnd_busy", busy_o, m_stream || m_ov);
      chk("rnd_rrow", rf_rrowaddr_o, m_row);
      if (m_stream) chk("rnd_raddr", rf_raddr_o, m_reg);
      if (m_ov) begin
        chk("rnd_idx", row_idx_o, m_oidx);
        chk("rnd_last", row_last_o, m_olast);
        chk("rnd_id", row_id_o, m_oid);
        chk("rnd_data", row_data_o, rf_word(m_oreg, m_oidx));
      end
      if (w >= 0) $display("txn rnd cyc=%0d id=%0d reg=%0d", cyc, w, int'(req_reg_i[w*RW +: RW]));
      prev_gnt = req_ready_o;
      // Advance the model by one clock edge using the inputs just applied
      if (fl) begin
        m_stream = 0; m_row = 0; m_ov = 0;
      end else if (!m_stream) begin
        if (m_ov && row_ready_i) m_ov = 0;
        if (w >= 0) begin
          m_stream = 1; m_reg = int'(req_reg_i[w*RW +: RW]); m_id = w; m_row = 0;
          m_rr = (w + 1) % N_REQ;
        end
      end else if (!m_ov || row_ready_i) begin
        m_ov = 1; m_oidx = m_row; m_oid = m_id; m_oreg = m_reg;
        m_olast = (m_row == N_ROWS - 1);
        if (m_row == N_ROWS - 1) begin m_stream = 0; m_row = 0; end
        else m_row++;
      end
      @(negedge clk_i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
